// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR scheduler and the LFSR it drives:
// scheduler state encoding, default seed and seed width.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    GATHER,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// ptr_i+1, wrapping modulo NREQ. Returns one-hot grant, index and any-flag.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IDX_W = $clog2(NREQ);

  always_comb begin
    int cand;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o                  = 1'b1;
        idx_o                  = cand[IDX_W-1:0];
        gnt_o[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_sched.sv
// Round-robin scheduler sharing one serial LFSR between NREQ word requesters.
// Define LFSR_STALL_DET_EN to add the stuck-LFSR watchdog and stall_seen port.
module lfsr_rand_sched
  import lfsr_pkg::*;
#(
  parameter int                NREQ         = 2,
  parameter int                WORD_W       = 8,
  parameter int                LFSR_W       = lfsr_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  input  logic              seed_req,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              seed_ack,
  input  logic              lfsr_q,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_load
`ifdef LFSR_STALL_DET_EN
  ,
  output logic              stall_seen
`endif
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  state_e              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic                ack_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                seed_ack_q;
  logic                load_q;
  logic                seed_pend_q;
  logic [LFSR_W-1:0]   seed_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   word_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                stall_force;
  logic                stall_take;

  // A zero seed would lock the LFSR at zero forever.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // First collected bit ends up as the MSB of the word.
  if (WORD_W > 1) begin : g_shift
    logic [WORD_W-2:0] sreg_q;
    always_ff @(posedge clk) begin
      if (state_q == GATHER) sreg_q <= word_d[WORD_W-2:0];
    end
    assign word_d = {sreg_q, lfsr_q};
  end else begin : g_bit
    assign word_d = lfsr_q;
  end

  assign stall_take = (state_q == IDLE) && stall_force;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEED;
      gnt_q       <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      seed_ack_q  <= 1'b0;
      load_q      <= 1'b0;
      seed_pend_q <= 1'b0;
      seed_q      <= DEFAULT_SEED;
      rr_ptr_q    <= IDX_W'(NREQ - 1);
      cnt_q       <= '0;
    end else begin
      ack_q      <= 1'b0;
      seed_ack_q <= 1'b0;
      case (state_q)
        SEED: begin
          // Coming out of reset load_q is still low: raise it for one cycle first.
          if (!load_q) begin
            load_q <= 1'b1;
          end else begin
            load_q      <= 1'b0;
            seed_ack_q  <= seed_pend_q;
            seed_pend_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        IDLE: begin
          if (stall_take) begin
            seed_q      <= DEFAULT_SEED;
            load_q      <= 1'b1;
            seed_pend_q <= 1'b0;
            state_q     <= SEED;
          end else if (seed_req && !seed_ack_q) begin
            seed_q      <= seed_fix(seed_in);
            load_q      <= 1'b1;
            seed_pend_q <= 1'b1;
            state_q     <= SEED;
          end else if (arb_any) begin
            gnt_q    <= arb_gnt;
            rr_ptr_q <= arb_idx;
            cnt_q    <= '0;
            state_q  <= GATHER;
          end
        end
        GATHER: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            rdata_q <= word_d;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= SEED;
      endcase
    end
  end

`ifdef LFSR_STALL_DET_EN
  localparam logic [LFSR_W:0] STALL_LIM = {1'b1, {LFSR_W{1'b0}}};

  logic              q_prev_q;
  logic              stall_pend_q;
  logic              stall_seen_q;
  logic [LFSR_W:0]   run_q;

  // run_q counts consecutive cycles with an unchanged serial bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_prev_q     <= 1'b0;
      run_q        <= '0;
      stall_pend_q <= 1'b0;
      stall_seen_q <= 1'b0;
    end else begin
      q_prev_q <= lfsr_q;
      if (stall_take || (lfsr_q != q_prev_q)) begin
        run_q <= '0;
      end else if (run_q != STALL_LIM) begin
        run_q <= run_q + (LFSR_W + 1)'(1);
      end
      if (stall_take) begin
        stall_pend_q <= 1'b0;
      end else if (run_q == STALL_LIM) begin
        stall_pend_q <= 1'b1;
        stall_seen_q <= 1'b1;
      end
    end
  end

  assign stall_force = stall_pend_q;
  assign stall_seen  = stall_seen_q;
`else
  assign stall_force = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign seed_ack  = seed_ack_q;
  assign lfsr_seed = seed_q;
  assign lfsr_load = load_q;

endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Scoreboard bench for lfsr_rand_sched with a 4-bit x^4+x^3+1 LFSR model
// driving lfsr_q; the stall section is built when LFSR_STALL_DET_EN is defined.
module tb_lfsr_rand_sched;

  localparam int NREQ   = 2;
  localparam int WORD_W = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic              ack;
  logic [WORD_W-1:0] rdata;
  logic              seed_req;
  logic [3:0]        seed_in;
  logic              seed_ack;
  logic              lfsr_q;
  logic [3:0]        lfsr_seed;
  logic              lfsr_load;
`ifdef LFSR_STALL_DET_EN
  logic              stall_seen;
`endif

  lfsr_rand_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .seed_req  (seed_req),
    .seed_in   (seed_in),
    .seed_ack  (seed_ack),
    .lfsr_q    (lfsr_q),
    .lfsr_seed (lfsr_seed),
    .lfsr_load (lfsr_load)
`ifdef LFSR_STALL_DET_EN
    ,
    .stall_seen(stall_seen)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // LFSR model (x^4+x^3+1, serial bit = MSB); from 1001 the bits run 1,0,0,1,1,0,1,0,1,...
  logic [3:0] st = 4'b0000;
  logic       force0 = 1'b0;
  always @(posedge clk) begin
    if (lfsr_load) st <= lfsr_seed;
    else           st <= {st[2:0], st[3] ^ st[2]};
  end
  assign lfsr_q = force0 ? 1'b0 : st[3];

  // The last WORD_W serial bits seen at rising edges, oldest in the MSB.
  logic [WORD_W-1:0] hist = '0;
  always @(posedge clk) hist <= {hist[WORD_W-2:0], lfsr_q};

  typedef struct {
    int               idx;
    bit               use_const;
    logic [WORD_W-1:0] word;
  } exp_t;
  exp_t sb[$];

  int nvec = 0;
  int nerr = 0;
  int load_cnt = 0, seed_ack_cnt = 0, ack_cnt = 0;
  int gnt_multi = 0, load_busy = 0, ack_double = 0;
  logic [3:0] last_load_seed = 4'b0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: event counters, invariants, and scoreboard pop on each ack.
  initial begin
    exp_t e;
    bit   ack_prev;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_prev = 1'b0;
      end else begin
        if (lfsr_load) begin
          load_cnt++;
          last_load_seed = lfsr_seed;
          if (gnt != '0) load_busy++;
        end
        if (seed_ack) seed_ack_cnt++;
        if (!$onehot0(gnt)) gnt_multi++;
        if (ack && ack_prev) ack_double++;
        ack_prev = ack;
        if (ack) begin
          ack_cnt++;
          chk("sb_pending", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("gnt_at_ack", 32'(gnt), 32'(1 << e.idx));
            chk("rdata_model", 32'(rdata), 32'(hist));
            if (e.use_const) chk("rdata_const", 32'(rdata), 32'(e.word));
          end
        end
      end
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 60; i++) begin
      settle();
      if (ack) begin
        g  = gnt;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 32'(ack), 1);
  endtask

  task automatic wait_seed_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      settle();
      if (seed_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("seed_ack_timeout", 32'(seed_ack), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},       32'(gnt), 0);
    chk({tag, "_ack"},       32'(ack), 0);
    chk({tag, "_rdata"},     32'(rdata), 0);
    chk({tag, "_load"},      32'(lfsr_load), 0);
    chk({tag, "_seed"},      32'(lfsr_seed), 32'h9);
    chk({tag, "_seed_ack"},  32'(seed_ack), 0);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    bit   ok;
    int   cyc, idx, base_sa, base_ack, base_load;
    int   served [NREQ];
    exp_t e;

    rst = 1'b1; req = '0; seed_req = 1'b0; seed_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk_reset_outputs("rst0");

    // Post-reset seeding: one load cycle carrying 1001, no seed_ack.
    @(posedge clk);
    settle();
    chk("post_rst_load", 32'(lfsr_load), 1);
    chk("post_rst_seed", 32'(lfsr_seed), 32'h9);
    @(posedge clk);
    #1;
    e = '{idx: 0, use_const: 1'b1, word: 8'h35};
    sb.push_back(e);
    req = 2'b01;
    settle();
    chk("load_one_cycle", 32'(lfsr_load), 0);
    chk("load_cnt_rst", 32'(load_cnt), 1);
    chk("no_seed_ack_rst", 32'(seed_ack_cnt), 0);

    // First word: bits 1..8 after the 1001 load -> 0011_0101, ack after 9 edges.
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      cyc++;
      settle();
      if (ack) ok = 1'b1;
    end
    chk("ack_latency", 32'(cyc), 9);
    @(posedge clk);
    #1 req = '0;

    // Both requesters held from a fresh reset: service order 0,1,0,1.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base_ack = ack_cnt;
    for (int k = 0; k < 4; k++) begin
      e = '{idx: k % 2, use_const: 1'b0, word: '0};
      sb.push_back(e);
    end
    served[0] = 0;
    served[1] = 0;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(g, ok);
      if (!ok) break;
      @(posedge clk);
      #1 req = req & ~g;
      idx = g[1] ? 1 : 0;
      served[idx]++;
      if (served[idx] < 2) begin
        @(posedge clk);
        #1 req = req | g;
      end
    end
    req = '0;
    repeat (3) settle();
    chk("rr_ack_count", 32'(ack_cnt - base_ack), 4);

    // Idle reseed with 0110.
    base_sa = seed_ack_cnt;
    seed_in = 4'b0110;
    seed_req = 1'b1;
    wait_seed_ack(ok);
    @(posedge clk);
    #1 seed_req = 1'b0;
    chk("seed_0110", 32'(lfsr_seed), 32'h6);
    chk("load_seed_0110", 32'(last_load_seed), 32'h6);
    repeat (3) settle();
    chk("seed_ack_once", 32'(seed_ack_cnt - base_sa), 1);

    // Zero-seed reseed requested mid-word: word finishes first, seed becomes 1001.
    e = '{idx: 0, use_const: 1'b0, word: '0};
    sb.push_back(e);
    base_sa = seed_ack_cnt;
    @(posedge clk);
    #1 req = 2'b01;
    repeat (3) @(posedge clk);
    #1 seed_in = 4'b0000;
    seed_req = 1'b1;
    wait_ack(g, ok);
    chk("reseed_deferred", 32'(seed_ack_cnt - base_sa), 0);
    @(posedge clk);
    #1 req = '0;
    wait_seed_ack(ok);
    @(posedge clk);
    #1 seed_req = 1'b0;
    chk("seed_zero_fix", 32'(lfsr_seed), 32'h9);
    chk("load_seed_fix", 32'(last_load_seed), 32'h9);

`ifdef LFSR_STALL_DET_EN
    // Stuck serial bit: watchdog forces a 1001 reload with no seed_ack.
    seed_in = 4'b0110;
    seed_req = 1'b1;
    wait_seed_ack(ok);
    @(posedge clk);
    #1 seed_req = 1'b0;
    repeat (2) settle();
    chk("stall_clear", 32'(stall_seen), 0);
    base_sa   = seed_ack_cnt;
    base_load = load_cnt;
    @(posedge clk);
    #1 force0 = 1'b1;
    repeat (20) @(posedge clk);
    #1 force0 = 1'b0;
    repeat (15) settle();
    chk("stall_seen", 32'(stall_seen), 1);
    chk("stall_reload_cnt", 32'(load_cnt - base_load), 1);
    chk("stall_reload_seed", 32'(last_load_seed), 32'h9);
    chk("stall_no_seed_ack", 32'(seed_ack_cnt - base_sa), 0);
`endif

    // Reset three bits into a word: no ack, reset outputs, seeding reruns.
    base_ack  = ack_cnt;
    base_load = load_cnt;
    @(posedge clk);
    #1 req = 2'b10;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    req = '0;
    settle();
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) settle();
    chk("rst_mid_no_ack", 32'(ack_cnt - base_ack), 0);
    chk("rst_mid_reseed", 32'(load_cnt - base_load), 1);
    chk("rst_mid_seed_val", 32'(last_load_seed), 32'h9);

    chk("gnt_onehot0", 32'(gnt_multi), 0);
    chk("no_load_while_busy", 32'(load_busy), 0);
    chk("ack_single_cycle", 32'(ack_double), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lfsr_rand_sched.md
Name: lfsr_rand_sched

Overview:
- Round-robin scheduler that shares one `lfsr` instance (4-bit, serial output `q`, `seed`/`load` inputs) between NREQ requesters.
- Each word request is served by collecting WORD_W consecutive `q` bits into one random word.
- Sequences seeding after reset and on explicit reseed requests, so the LFSR is never left unseeded or all-zero.
- Sits between the karaoke effect/shuffle blocks and the single `lfsr`.

Parameters:
- NREQ, 2, number of word requesters (2..8).
- WORD_W, 8, bits per returned word (1..16).
- LFSR_W, 4, LFSR seed width.
- DEFAULT_SEED, 4'b1001, seed used after reset and in place of any zero seed.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester word request; level, held until that requester's ack.
- gnt  out  NREQ  one-hot, registered; identifies the requester being served.
- ack  out  1  one-cycle pulse; `rdata` valid for requester `gnt`.
- rdata  out  WORD_W  random word.
- seed_req  in  1  reseed request; level, held until seed_ack.
- seed_in  in  LFSR_W  requested seed; sampled when SEED is entered.
- seed_ack  out  1  one-cycle pulse; reseed performed.
- lfsr_q  in  1  LFSR serial bit (`q`).
- lfsr_seed  out  LFSR_W  to LFSR `seed`.
- lfsr_load  out  1  to LFSR `load`.

Behaviour:
- Reset values:
  - state = SEED; gnt = 0, ack = 0, rdata = 0, seed_ack = 0.
  - lfsr_load = 0, lfsr_seed = DEFAULT_SEED.
  - rr_ptr = NREQ-1, so requester 0 wins first; bit counter = 0.
- States are IDLE, SEED, GATHER, DONE. All outputs are registered.
- SEED:
  - Occupies exactly one cycle with lfsr_load = 1.
  - Next state is IDLE, with lfsr_load <= 0.
  - seed_ack pulses in the cycle after SEED only if the entry came from seed_req; no pulse for the post-reset seeding.
- IDLE:
  - seed_req has priority over any req.
    - On seed_req: lfsr_seed <= (seed_in == 0 ? DEFAULT_SEED : seed_in); go to SEED.
  - Otherwise, if any req is set, grant the first set bit searching upward from rr_ptr+1 (wrapping mod NREQ).
    - gnt <= onehot; rr_ptr <= index; counter <= 0; go to GATHER.
- GATHER:
  - Each edge: shift register <= {sreg[WORD_W-2:0], lfsr_q} (first bit ends up as the MSB); counter increments.
  - On the edge where counter == WORD_W-1: rdata <= {sreg, lfsr_q}, ack <= 1, go to DONE.
  - Latency: req sampled at edge E gives ack high during the cycle after edge E+WORD_W.
- DONE:
  - ack = 1 for this single cycle, then ack <= 0, gnt <= 0, go to IDLE.
  - The requester drops req at the edge it registers ack. req is not sampled in DONE, so the same request is never double-served.
- Sequencing guarantees:
  - seed_req asserted during GATHER or DONE waits for IDLE; a word is never built across a reseed.
  - No lfsr_load during GATHER.
  - req withdrawn during GATHER is not supported; the word is still completed and acked.
- rst asserted mid-operation: immediate return to reset values; the in-flight word is discarded with no ack; SEED reruns.

Optional Feature:
- LFSR_STALL_DET_EN, defined:
  - A watchdog counts consecutive cycles with lfsr_q unchanged.
  - At 2^LFSR_W cycles, the next IDLE forces SEED with DEFAULT_SEED, with no seed_ack.
  - Output `stall_seen` (1 bit) becomes sticky high until rst.
- LFSR_STALL_DET_EN undefined: no watchdog, no `stall_seen` port, behaviour otherwise identical.

Decomposition:
- Package `lfsr_pkg`:
  - state enum (IDLE/SEED/GATHER/DONE).
  - DEFAULT_SEED constant and LFSR_W.
  - Shared by this block and the `lfsr`.
- One sub-module, `rr_arbiter`: combinational round-robin pick over NREQ given rr_ptr, returning a one-hot and an index.

Test Plan:
- Reset release, no requests -> lfsr_load high exactly 1 cycle with lfsr_seed = 4'b1001; no seed_ack.
- req = 2'b01, WORD_W = 8 -> gnt = 01, ack 9 cycles after req sampled; rdata equals 8 bits from the `lfsr` model seeded with 1001, first bit as MSB.
- req = 2'b11 held -> service order 0,1,0,1; exactly one ack per grant; gnt never two-hot.
- seed_req with seed_in = 0 during GATHER -> current word completes first, then lfsr_seed = 1001 and a seed_ack pulse; seed_in = 4'b0110 -> lfsr_seed = 0110.
- rst pulsed at gather bit 3 -> ack never pulses, outputs at reset values, SEED repeats.
- LFSR_STALL_DET_EN defined, lfsr_q forced 0 for 16 cycles -> stall_seen = 1 and forced reload with 1001.
